music_score_recorder: RTL and testbench

Write-side counterpart of the score playback path: samples the live note/octave selection every millisecond while recording is enabled, run-length encodes it, and writes 24-bit score entries {length[15:0], note[3:0], octave[3:0]} into the 256-entry score RAM that playback reads. The format is identical to the playback format, so a recorded score replays with the same durations. The block sits between the keyboard decoder and the score RAM write port.

---
 rtl/score_pkg.sv | 40 ++++
 rtl/music_score_recorder_if.sv | 28 ++
 rtl/score_run_counter.sv | 27 ++
 rtl/music_score_recorder.sv | 112 +++++++++++
 tb/tb_music_score_recorder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared score-entry field definitions for the recorder and playback paths.
// Latency: n/a (types, constants and pack/unpack helpers only).
// Backpressure: n/a.
package score_pkg;

  localparam int LEN_W   = 16;
  localparam int NOTE_W  = 4;
  localparam int OCT_W   = 4;
  localparam int ENTRY_W = LEN_W + NOTE_W + OCT_W;

  localparam logic [NOTE_W-1:0] END_NOTE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_TERM  = 2'd2,
    ST_DONE  = 2'd3
  } rec_state_t;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  oct;
  } entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [LEN_W-1:0]  len,
                                                    input logic [NOTE_W-1:0] note,
                                                    input logic [OCT_W-1:0]  oct);
    entry_t e;
    e.len  = len;
    e.note = note;
    e.oct  = oct;
    return e;
  endfunction

  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
    return entry_t'(raw);
  endfunction

endpackage

// File: rtl/music_score_recorder_if.sv
// music_score_recorder_if: keyboard-side inputs, score RAM write port and take status.
// Latency: n/a (wiring only). master = recorder, slave = keyboard/RAM/controller side.
// Backpressure: none; the RAM write port accepts one write per cycle unconditionally.
interface music_score_recorder_if #(parameter int ADDR_W = 8);
  import score_pkg::*;

  logic               en;
  logic [NOTE_W-1:0]  note_in;
  logic [OCT_W-1:0]   octave_in;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic [ADDR_W-1:0]  note_count;
  logic               recording;
  logic               done;
  logic               full;

  modport master (
    input  en, note_in, octave_in,
    output wr_en, wr_addr, wr_data, note_count, recording, done, full
  );

  modport slave (
    output en, note_in, octave_in,
    input  wr_en, wr_addr, wr_data, note_count, recording, done, full
  );

endinterface

// File: rtl/score_run_counter.sv
// score_run_counter: saturating run-length counter with load-to-1 and terminal-count flag.
// Latency: count updates on the edge after load1/inc; tc is combinational from count.
// Backpressure: none; inc is ignored while saturated, load1 has priority over inc.
module score_run_counter #(
  parameter int W = 16
) (
  input  logic         clk_1ms,
  input  logic         rst_n,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = &count;

  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load1) begin
      count <= W'(1);
    end else if (inc && !tc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/music_score_recorder.sv
// music_score_recorder: run-length encodes the note/octave sampled each ms into score RAM entries.
// Latency: write strobe one cycle after the causing sample; terminator two cycles after en falls.
// Backpressure: none; at most one RAM write per cycle, take ends itself when the RAM fills.
// Ports: clk_1ms, rst_n (async, active-low); bus = en/note_in/octave_in in,
//        wr_en/wr_addr/wr_data RAM write port and note_count/recording/done/full status out.
module music_score_recorder
  import score_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [NOTE_W-1:0] END_NOTE = score_pkg::END_NOTE
) (
  input  logic                   clk_1ms,
  input  logic                   rst_n,
  music_score_recorder_if.master bus
);

  // Last data address; the one after it is kept free so the terminator always fits.
  localparam logic [ADDR_W-1:0] FILL_PTR = {{(ADDR_W-1){1'b1}}, 1'b0};

  rec_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic [NOTE_W-1:0] held_note;
  logic [OCT_W-1:0]  held_oct;
  logic [LEN_W-1:0]  run_len;
  logic              run_tc;
  logic              start;
  logic              same;
  logic              cnt_load;
  logic              cnt_inc;

  always_comb begin
    // A full take must see en low before a new take may start.
    start    = bus.en && ((state == ST_IDLE) || ((state == ST_DONE) && !bus.full));
    same     = (bus.note_in == held_note) && (bus.octave_in == held_oct);
    cnt_load = start || ((state == ST_TRACK) && bus.en && (!same || run_tc));
    cnt_inc  = (state == ST_TRACK) && bus.en && same && !run_tc;
  end

  score_run_counter #(.W(LEN_W)) u_run_counter (
    .clk_1ms (clk_1ms),
    .rst_n   (rst_n),
    .load1   (cnt_load),
    .inc     (cnt_inc),
    .count   (run_len),
    .tc      (run_tc)
  );

  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      held_note      <= '0;
      held_oct       <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.note_count <= '0;
      bus.recording  <= 1'b0;
      bus.done       <= 1'b0;
      bus.full       <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            held_note      <= bus.note_in;
            held_oct       <= bus.octave_in;
            ptr            <= '0;
            bus.note_count <= '0;
            bus.full       <= 1'b0;
            bus.done       <= 1'b0;
            bus.recording  <= 1'b1;
            state          <= ST_TRACK;
          end else if (state == ST_DONE) begin
            bus.done <= 1'b1;
            if (!bus.en) bus.full <= 1'b0;
          end
        end

        ST_TRACK: begin
          // en low, a note change or a saturated run each flush exactly one entry.
          if (!bus.en || !same || run_tc) begin
            bus.wr_en      <= 1'b1;
            bus.wr_addr    <= ptr;
            bus.wr_data    <= pack_entry(run_len, held_note, held_oct);
            ptr            <= ptr + ADDR_W'(1);
            bus.note_count <= bus.note_count + ADDR_W'(1);
            if (bus.en) begin
              held_note <= bus.note_in;
              held_oct  <= bus.octave_in;
            end
            if (!bus.en || (ptr == FILL_PTR)) begin
              state         <= ST_TERM;
              bus.recording <= 1'b0;
              if (ptr == FILL_PTR) bus.full <= 1'b1;
            end
          end
        end

        ST_TERM: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= ptr;
          bus.wr_data <= pack_entry(LEN_W'(1), END_NOTE, '0);
          state       <= ST_DONE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_score_recorder.sv
// tb_music_score_recorder: directed takes against hand-computed score entries.
// Latency: inputs driven on falling edges, outputs sampled on falling edges / 1 unit after rising.
// Backpressure: n/a; every RAM write strobe is logged and compared.
module tb_music_score_recorder;

  localparam int ADDR_W = 8;

  logic clk_1ms = 1'b0;
  logic rst_n   = 1'b0;

  always #5 clk_1ms = ~clk_1ms;

  music_score_recorder_if #(.ADDR_W(ADDR_W)) bus ();

  music_score_recorder #(.ADDR_W(ADDR_W), .END_NOTE(4'hF)) dut (
    .clk_1ms (clk_1ms),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int          wq_addr[$];
  logic [23:0] wq_data[$];

  always @(posedge clk_1ms) begin
    #1;
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(int'(bus.wr_addr));
      wq_data.push_back(bus.wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic logic [23:0] ent(input int len, input int n, input int o);
    logic [15:0] l16 = len[15:0];
    logic [3:0]  n4  = n[3:0];
    logic [3:0]  o4  = o[3:0];
    return {l16, n4, o4};
  endfunction

  function automatic logic [31:0] q_addr(input int i);
    return (i < wq_addr.size()) ? wq_addr[i] : 32'hDEAD;
  endfunction

  function automatic logic [31:0] q_data(input int i);
    return (i < wq_data.size()) ? {8'h00, wq_data[i]} : 32'hDEAD;
  endfunction

  task automatic drive(input logic e, input logic [3:0] n, input logic [3:0] o);
    bus.en        = e;
    bus.note_in   = n;
    bus.octave_in = o;
    @(negedge clk_1ms);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge clk_1ms);
      k++;
    end
    check(tag, {31'd0, bus.done}, 32'd1);
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"},  {31'd0, bus.wr_en},     32'd0);
    check({tag, "_wr_addr"}, {24'd0, bus.wr_addr},  32'd0);
    check({tag, "_wr_data"}, {8'd0, bus.wr_data},   32'd0);
    check({tag, "_count"},  {24'd0, bus.note_count}, 32'd0);
    check({tag, "_rec"},    {31'd0, bus.recording}, 32'd0);
    check({tag, "_done"},   {31'd0, bus.done},      32'd0);
    check({tag, "_full"},   {31'd0, bus.full},      32'd0);
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.note_in   = 4'd0;
    bus.octave_in = 4'd0;
    repeat (3) @(negedge clk_1ms);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk_1ms);

    // Take 1: one note held 5 ms.
    clear_log();
    for (int i = 0; i < 5; i++) drive(1'b1, 4'd3, 4'd4);
    check("t1_recording", {31'd0, bus.recording}, 32'd1);
    drive(1'b0, 4'd3, 4'd4);
    wait_done("t1_done");
    check("t1_nwrites", wq_addr.size(), 32'd2);
    check("t1_a0", q_addr(0), 32'd0);
    check("t1_d0", q_data(0), {8'd0, ent(5, 3, 4)});
    check("t1_a1", q_addr(1), 32'd1);
    check("t1_d1", q_data(1), {8'd0, ent(1, 15, 0)});
    check("t1_count", {24'd0, bus.note_count}, 32'd1);
    check("t1_full", {31'd0, bus.full}, 32'd0);
    check("t1_rec_off", {31'd0, bus.recording}, 32'd0);

    // Take 2: notes 1,1,2,2,2,0, started from DONE.
    clear_log();
    drive(1'b1, 4'd1, 4'd2);
    drive(1'b1, 4'd1, 4'd2);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd2, 4'd2);
    drive(1'b1, 4'd0, 4'd2);
    drive(1'b0, 4'd0, 4'd2);
    wait_done("t2_done");
    check("t2_nwrites", wq_addr.size(), 32'd4);
    check("t2_d0", q_data(0), {8'd0, ent(2, 1, 2)});
    check("t2_d1", q_data(1), {8'd0, ent(3, 2, 2)});
    check("t2_d2", q_data(2), {8'd0, ent(1, 0, 2)});
    check("t2_a3", q_addr(3), 32'd3);
    check("t2_d3", q_data(3), {8'd0, ent(1, 15, 0)});
    check("t2_count", {24'd0, bus.note_count}, 32'd3);

    // Take 3: 65537 ms of one note splits at the saturation length.
    clear_log();
    for (int i = 0; i < 65537; i++) drive(1'b1, 4'd5, 4'd1);
    drive(1'b0, 4'd5, 4'd1);
    wait_done("t3_done");
    check("t3_nwrites", wq_addr.size(), 32'd3);
    check("t3_d0", q_data(0), {8'd0, ent(65535, 5, 1)});
    check("t3_d1", q_data(1), {8'd0, ent(2, 5, 1)});
    check("t3_a2", q_addr(2), 32'd2);
    check("t3_d2", q_data(2), {8'd0, ent(1, 15, 0)});
    check("t3_count", {24'd0, bus.note_count}, 32'd2);

    // Take 4: note changes every ms for 300 ms fills the RAM.
    clear_log();
    for (int i = 0; i < 300; i++) drive(1'b1, (i % 2 == 1) ? 4'd2 : 4'd1, 4'd3);
    check("t4_nwrites", wq_addr.size(), 32'd256);
    check("t4_d0", q_data(0), {8'd0, ent(1, 1, 3)});
    check("t4_d1", q_data(1), {8'd0, ent(1, 2, 3)});
    check("t4_a254", q_addr(254), 32'd254);
    check("t4_d254", q_data(254), {8'd0, ent(1, 1, 3)});
    check("t4_a255", q_addr(255), 32'd255);
    check("t4_d255", q_data(255), {8'd0, ent(1, 15, 0)});
    check("t4_count", {24'd0, bus.note_count}, 32'd255);
    check("t4_done", {31'd0, bus.done}, 32'd1);
    check("t4_full", {31'd0, bus.full}, 32'd1);
    check("t4_rec_off", {31'd0, bus.recording}, 32'd0);
    drive(1'b0, 4'd1, 4'd3);
    check("t4_full_clr", {31'd0, bus.full}, 32'd0);
    check("t4_done_hold", {31'd0, bus.done}, 32'd1);
    drive(1'b1, 4'd6, 4'd3);
    check("t4_restart_rec", {31'd0, bus.recording}, 32'd1);
    check("t4_restart_done", {31'd0, bus.done}, 32'd0);
    drive(1'b0, 4'd6, 4'd3);
    wait_done("t4_restart_fin");

    // Take 5: reset mid-take, then a fresh take from address 0.
    clear_log();
    for (int i = 0; i < 10; i++) drive(1'b1, 4'd7, 4'd2);
    rst_n  = 1'b0;
    bus.en = 1'b0;
    #1;
    check_idle_outputs("t5_rst");
    repeat (3) @(negedge clk_1ms);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 4'd7, 4'd2);
    check("t5_no_write", wq_addr.size(), 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd4, 4'd2);
    drive(1'b0, 4'd4, 4'd2);
    wait_done("t5_done");
    check("t5_a0", q_addr(0), 32'd0);
    check("t5_d0", q_data(0), {8'd0, ent(3, 4, 2)});

    // Take 6: en falls in the cycle the note changes.
    clear_log();
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd1, 4'd1);
    drive(1'b0, 4'd9, 4'd1);
    wait_done("t6_done");
    check("t6_nwrites", wq_addr.size(), 32'd2);
    check("t6_d0", q_data(0), {8'd0, ent(4, 1, 1)});
    check("t6_d1", q_data(1), {8'd0, ent(1, 15, 0)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
